// File: rtl/video_timing_gen_if.sv
// Raster and pixel-fetch signals shared by the timing generator,
// the pattern generator and the DVI encoder.
interface video_timing_gen_if;
  logic [23:0] pixel_data;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic        video_hs;
  logic        video_vs;
  logic        video_de;
  logic [23:0] video_rgb;
  logic        frame_start;

  modport master (
    input  pixel_data,
    output pixel_xpos,
    output pixel_ypos,
    output video_hs,
    output video_vs,
    output video_de,
    output video_rgb,
    output frame_start
  );

  modport slave (
    output pixel_data,
    input  pixel_xpos,
    input  pixel_ypos,
    input  video_hs,
    input  video_vs,
    input  video_de,
    input  video_rgb,
    input  frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// HSYNC/VSYNC/DE raster generator with one-pixel-early coordinate
// requests and a DE-gated pixel return path.
module video_timing_gen #(
  parameter logic [10:0] H_SYNC   = 11'd40,
  parameter logic [10:0] H_BACK   = 11'd220,
  parameter logic [10:0] H_DISP   = 11'd1280,
  parameter logic [10:0] H_FRONT  = 11'd110,
  parameter logic [10:0] H_TOTAL  = 11'd1650,
  parameter logic [10:0] V_SYNC   = 11'd5,
  parameter logic [10:0] V_BACK   = 11'd20,
  parameter logic [10:0] V_DISP   = 11'd720,
  parameter logic [10:0] V_FRONT  = 11'd5,
  parameter logic [10:0] V_TOTAL  = 11'd750,
  parameter logic        SYNC_POL = 1'b1
) (
  input logic               pixel_clk,
  input logic               sys_rst_n,
  video_timing_gen_if.master vid
);

  localparam logic [10:0] HA  = H_SYNC + H_BACK;
  localparam logic [10:0] HE  = HA + H_DISP;
  localparam logic [10:0] VA  = V_SYNC + V_BACK;
  localparam logic [10:0] VE  = VA + V_DISP;
  localparam logic [10:0] HR  = HA - 11'd1;
  localparam logic [10:0] HRE = HE - 11'd1;

  logic [10:0] cnt_h;
  logic [10:0] cnt_v;
  logic        h_end;
  logic        v_end;
  logic        h_act;
  logic        v_act;
  logic        req;

  logic        hs_q;
  logic        vs_q;
  logic        de_q;
  logic        fs_q;
  logic [10:0] x_q;
  logic [10:0] y_q;

  assign h_end = (cnt_h == H_TOTAL - 11'd1);
  assign v_end = (cnt_v == V_TOTAL - 11'd1);

  // pixel counter within the line
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      cnt_h <= '0;
    else if (h_end)
      cnt_h <= '0;
    else
      cnt_h <= cnt_h + 11'd1;
  end

  // line counter, advances on each line wrap
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      cnt_v <= '0;
    else if (h_end)
      cnt_v <= v_end ? 11'd0 : cnt_v + 11'd1;
  end

  // position decode; request window leads active video by one pixel
  always_comb begin
    h_act = (cnt_h >= HA) && (cnt_h < HE);
    v_act = (cnt_v >= VA) && (cnt_v < VE);
    req   = v_act && (cnt_h >= HR) && (cnt_h < HRE);
  end

  // all raster outputs registered from the same counter state
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hs_q <= ~SYNC_POL;
      vs_q <= ~SYNC_POL;
      de_q <= 1'b0;
      fs_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      hs_q <= (cnt_h < H_SYNC) ? SYNC_POL : ~SYNC_POL;
      vs_q <= (cnt_v < V_SYNC) ? SYNC_POL : ~SYNC_POL;
      de_q <= h_act && v_act;
      fs_q <= (cnt_h == 11'd0) && (cnt_v == 11'd0);
      x_q  <= req ? cnt_h - HR : 11'd0;
      y_q  <= req ? cnt_v - VA : 11'd0;
    end
  end

  assign vid.video_hs    = hs_q;
  assign vid.video_vs    = vs_q;
  assign vid.video_de    = de_q;
  assign vid.frame_start = fs_q;
  assign vid.pixel_xpos  = x_q;
  assign vid.pixel_ypos  = y_q;
  assign vid.video_rgb   = vid.pixel_data & {24{de_q}};

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: default 720p instance for early lines,
// small instance for whole frames, blanking and mid-frame reset.
module tb_video_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [10:0] x;
    logic [10:0] y;
    logic [23:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic white_b = 1'b0;
  logic [23:0] pat_a = '0;
  logic [23:0] pat_b = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  video_timing_gen_if ia();
  video_timing_gen_if ib();

  video_timing_gen u_a (
    .pixel_clk (clk),
    .sys_rst_n (rst_a),
    .vid       (ia.master)
  );

  video_timing_gen #(
    .H_SYNC(11'd2), .H_BACK(11'd2), .H_DISP(11'd4),
    .H_FRONT(11'd2), .H_TOTAL(11'd10),
    .V_SYNC(11'd1), .V_BACK(11'd1), .V_DISP(11'd3),
    .V_FRONT(11'd1), .V_TOTAL(11'd6),
    .SYNC_POL(1'b0)
  ) u_b (
    .pixel_clk (clk),
    .sys_rst_n (rst_b),
    .vid       (ib.master)
  );

  // pattern generators: one-cycle register of {y[7:0], x, 5'b0}
  always @(posedge clk) pat_a <= {ia.pixel_ypos[7:0], ia.pixel_xpos, 5'b0};
  always @(posedge clk) pat_b <= {ib.pixel_ypos[7:0], ib.pixel_xpos, 5'b0};
  assign ia.pixel_data = pat_a;
  assign ib.pixel_data = white_b ? 24'hFFFFFF : pat_b;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // expected outputs t cycles after the first edge following reset
  function automatic exp_t calc(input int t, input int hsy, input int hbk,
                                input int hds, input int htot, input int vsy,
                                input int vbk, input int vds, input int vtot,
                                input bit pol, input bit white);
    exp_t e;
    int h, v, ha, va;
    h  = t % htot;
    v  = (t / htot) % vtot;
    ha = hsy + hbk;
    va = vsy + vbk;
    e.hs = (h < hsy) ? pol : !pol;
    e.vs = (v < vsy) ? pol : !pol;
    e.fs = (h == 0) && (v == 0);
    e.de = (h >= ha) && (h < ha + hds) && (v >= va) && (v < va + vds);
    e.x  = '0;
    e.y  = '0;
    if ((h >= ha - 1) && (h < ha + hds - 1) && (v >= va) && (v < va + vds)) begin
      e.x = 11'(h - ha + 1);
      e.y = 11'(v - va);
    end
    e.rgb = white ? 24'hFFFFFF : {8'(v - va), 11'(h - ha), 5'b0};
    return e;
  endfunction

  int   ta  = -1;
  int   tbc = -1;
  exp_t ea;
  exp_t eb;
  exp_t qa[$];
  exp_t qb[$];

  // stimulus-side model: push each expected DE pixel as it is issued
  always @(posedge clk) begin
    if (!rst_a) ta = -1;
    else begin
      ta++;
      ea = calc(ta, 40, 220, 1280, 1650, 5, 20, 720, 750, 1'b1, 1'b0);
      if (ea.de) qa.push_back(ea);
    end
  end

  always @(posedge clk) begin
    if (!rst_b) tbc = -1;
    else begin
      tbc++;
      eb = calc(tbc, 2, 2, 4, 10, 1, 1, 3, 6, 1'b0, white_b);
      if (eb.de) qb.push_back(eb);
    end
  end

  always @(negedge rst_a) qa.delete();
  always @(negedge rst_b) qb.delete();

  // stats for the default instance
  int   a_hs_cnt = 0, a_vs_cnt = 0, a_de25 = 0;
  int   a_hs_rise = -1, a_first_de = -1, a_de_gap = -1;
  logic a_prev_hs = 1'b0;
  logic [23:0] a_first_rgb = 24'hBAD, a_last_rgb = 24'hFFFFFF;

  // monitor for the default instance
  always @(negedge clk) begin
    exp_t p;
    if (!rst_a) begin
      chk("a_rst_hs", ia.video_hs, 0);
      chk("a_rst_vs", ia.video_vs, 0);
      chk("a_rst_de", ia.video_de, 0);
      chk("a_rst_fs", ia.frame_start, 0);
      chk("a_rst_rgb", ia.video_rgb, 0);
    end else if (ta < 26 * 1650) begin
      chk("a_hs", ia.video_hs, ea.hs);
      chk("a_vs", ia.video_vs, ea.vs);
      chk("a_de", ia.video_de, ea.de);
      chk("a_fs", ia.frame_start, ea.fs);
      chk("a_x", ia.pixel_xpos, ea.x);
      chk("a_y", ia.pixel_ypos, ea.y);
      if (ia.video_de) begin
        if (qa.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL a_rgb_queue: DE with no expected pixel, rgb %0h", ia.video_rgb);
        end else begin
          p = qa.pop_front();
          chk("a_rgb", ia.video_rgb, p.rgb);
        end
      end else begin
        chk("a_rgb_blank", ia.video_rgb, 0);
      end
      if (ia.video_hs && !a_prev_hs) a_hs_rise = ta;
      if (ta < 1650 && ia.video_hs) a_hs_cnt++;
      if (ia.video_vs) a_vs_cnt++;
      if (ia.video_de) begin
        if (a_first_de < 0) begin
          a_first_de  = ta;
          a_de_gap    = ta - a_hs_rise;
          a_first_rgb = ia.video_rgb;
        end
        if (ta / 1650 == 25) a_de25++;
        if (ta == 25 * 1650 + 260 + 1279) a_last_rgb = ia.video_rgb;
      end
    end
    a_prev_hs = ia.video_hs;
  end

  // stats for the small instance
  int b_hs_low = 0, b_de = 0, b_de_lines = 0, b_fs_prev = -1;
  logic [23:0] b_c00 = 24'hBAD, b_c30 = 24'hBAD;
  logic [23:0] b_c02 = 24'hBAD, b_c32 = 24'hBAD;

  // monitor for the small instance
  always @(negedge clk) begin
    exp_t p;
    if (!rst_b) begin
      b_fs_prev = -1;
      chk("b_rst_hs", ib.video_hs, 1);
      chk("b_rst_vs", ib.video_vs, 1);
      chk("b_rst_de", ib.video_de, 0);
      chk("b_rst_fs", ib.frame_start, 0);
      chk("b_rst_x", ib.pixel_xpos, 0);
      chk("b_rst_y", ib.pixel_ypos, 0);
      chk("b_rst_rgb", ib.video_rgb, 0);
    end else begin
      chk("b_hs", ib.video_hs, eb.hs);
      chk("b_vs", ib.video_vs, eb.vs);
      chk("b_de", ib.video_de, eb.de);
      chk("b_fs", ib.frame_start, eb.fs);
      chk("b_x", ib.pixel_xpos, eb.x);
      chk("b_y", ib.pixel_ypos, eb.y);
      if (ib.video_de) begin
        if (qb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL b_rgb_queue: DE with no expected pixel, rgb %0h", ib.video_rgb);
        end else begin
          p = qb.pop_front();
          chk("b_rgb", ib.video_rgb, p.rgb);
        end
      end else begin
        chk("b_rgb_blank", ib.video_rgb, 0);
      end
      if (ib.frame_start) begin
        if (b_fs_prev >= 0) chk("b_fs_period", tbc - b_fs_prev, 60);
        b_fs_prev = tbc;
      end
      if (!white_b && tbc < 180) begin
        if (!ib.video_hs) b_hs_low++;
        if (ib.video_de) b_de++;
        if (ib.video_de && tbc % 10 == 4) b_de_lines++;
        if (tbc == 24) b_c00 = ib.video_rgb;
        if (tbc == 27) b_c30 = ib.video_rgb;
        if (tbc == 44) b_c02 = ib.video_rgb;
        if (tbc == 47) b_c32 = ib.video_rgb;
      end
    end
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // small mode: three frames, then reset at line 3, pixel 6
    k = 0;
    while (tbc != 216 && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 1000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL b_wait_reset_point: got tbc %0d expected 216", tbc);
    end
    chk("b_hs_low_3fr", b_hs_low, 36);
    chk("b_de_3fr", b_de, 36);
    chk("b_de_lines_3fr", b_de_lines, 9);
    chk("b_corner_0_0", b_c00, {8'd0, 11'd0, 5'd0});
    chk("b_corner_3_0", b_c30, {8'd0, 11'd3, 5'd0});
    chk("b_corner_0_2", b_c02, {8'd2, 11'd0, 5'd0});
    chk("b_corner_3_2", b_c32, {8'd2, 11'd3, 5'd0});

    #1 rst_b = 1'b0;
    #1;
    chk("b_async_hs", ib.video_hs, 1);
    chk("b_async_vs", ib.video_vs, 1);
    chk("b_async_de", ib.video_de, 0);
    chk("b_async_x", ib.pixel_xpos, 0);
    chk("b_async_y", ib.pixel_ypos, 0);
    chk("b_async_rgb", ib.video_rgb, 0);
    white_b = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_b = 1'b1;
    @(posedge clk);
    #1;
    chk("b_release_fs", ib.frame_start, 1);
    chk("b_release_hs", ib.video_hs, 0);
    chk("b_release_vs", ib.video_vs, 0);
    repeat (125) @(negedge clk);
    #1;
    chk("b_queue_drained", qb.size(), 0);

    // default mode: run through line 25
    k = 0;
    while (ta < 26 * 1650 && k < 50000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL a_wait_line26: got ta %0d expected %0d", ta, 26 * 1650);
    end
    #1;
    chk("a_hs_width", a_hs_cnt, 40);
    chk("a_vs_cycles", a_vs_cnt, 5 * 1650);
    chk("a_first_de_line", a_first_de / 1650, 25);
    chk("a_hs_to_de", a_de_gap, 260);
    chk("a_de_line25", a_de25, 1280);
    chk("a_corner_0_0", a_first_rgb, {8'd0, 11'd0, 5'd0});
    chk("a_corner_1279_0", a_last_rgb, {8'd0, 11'd1279, 5'd0});
    chk("a_queue_drained", qa.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
